// File: rtl/pal_pkg.sv
// Shared sizing helpers and state encoding for the PAL fuse loader.
package pal_pkg;

  function automatic int fuse_bits(input int n_in, input int n_terms);
    return n_terms * 2 * n_in;
  endfunction

  function automatic int num_words(input int bits, input int word_w);
    return (bits + word_w - 1) / word_w;
  endfunction

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_CSUM = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    LOAD = ST_LOAD,
    CSUM = ST_CSUM
  } state_e;

endpackage

// File: rtl/pal_fuse_shadow.sv
// Shadow register filled word by word; copied into the active fuse map on commit.
module pal_fuse_shadow #(
  parameter int WORD_W    = 8,
  parameter int NUM_WORDS = 5,
  parameter int FUSE_BITS = 40,
  parameter int IDX_W     = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr_i,
  input  logic                 wr_en_i,
  input  logic [IDX_W-1:0]     wr_idx_i,
  input  logic [WORD_W-1:0]    wr_data_i,
  input  logic                 commit_i,
  output logic [FUSE_BITS-1:0] fuse_map_o,
  output logic                 fuse_map_valid_o
);

  localparam int SHADOW_W = NUM_WORDS * WORD_W;

  logic [SHADOW_W-1:0]  shadow_q;
  logic [FUSE_BITS-1:0] map_q;
  logic                 valid_q;

  // NOTE: the shadow is ordinary flops, not a RAM, so it takes the async reset
  // like everything else; a reset must never leave a stale partial map behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q <= '0;
    end else if (clr_i) begin
      shadow_q <= '0;
    end else if (wr_en_i) begin
      for (int k = 0; k < NUM_WORDS; k++) begin
        if (wr_idx_i == IDX_W'(k)) shadow_q[k*WORD_W +: WORD_W] <= wr_data_i;
      end
    end
  end

  // Padding bits past FUSE_BITS stay in the shadow and never reach the array.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      map_q   <= '0;
      valid_q <= 1'b0;
    end else if (commit_i) begin
      map_q   <= shadow_q[FUSE_BITS-1:0];
      valid_q <= 1'b1;
    end
  end

  assign fuse_map_o       = map_q;
  assign fuse_map_valid_o = valid_q;

endmodule

// File: rtl/pal_fuse_loader.sv
// Word-serial, XOR-checksummed fuse-map loader committing atomically to the AND plane.
module pal_fuse_loader
  import pal_pkg::*;
#(
  parameter int NUM_INPUTS = 5,
  parameter int NUM_TERMS  = 4,
  parameter int WORD_W     = 8
) (
  input  logic                                            clk,
  input  logic                                            rst_n,
  input  logic                                            prog_start,
  input  logic                                            prog_abort,
  input  logic                                            prog_valid,
  input  logic [WORD_W-1:0]                               prog_data,
  output logic                                            prog_ready,
  output logic                                            prog_done,
  output logic                                            prog_err,
  output logic [pal_pkg::fuse_bits(NUM_INPUTS, NUM_TERMS)-1:0] fuse_map,
  output logic                                            fuse_map_valid
);

  localparam int FUSE_BITS = fuse_bits(NUM_INPUTS, NUM_TERMS);
  localparam int NUM_WORDS = num_words(FUSE_BITS, WORD_W);
  localparam int CNT_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

  state_e              state_q;
  logic [CNT_W-1:0]    count_q;
  logic [WORD_W-1:0]   acc_q;
  logic                ready_q;
  logic                done_q;
  logic                err_q;

  logic xfer;
  logic word_wr;
  logic csum_ok_commit;
  logic shadow_clr;

  // ready_q mirrors "state is LOAD or CSUM", so a transfer needs no state decode.
  assign xfer           = prog_valid && ready_q;
  assign shadow_clr     = !prog_abort && prog_start;
  assign word_wr        = !prog_abort && !prog_start && xfer && (state_q == LOAD);
  assign csum_ok_commit = !prog_abort && !prog_start && xfer && (state_q == CSUM)
                          && (prog_data == acc_q);

  // NOTE: every register here is assigned with <= so all updates see the
  // pre-edge values of each other, regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      count_q <= '0;
      acc_q   <= '0;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      if (prog_abort) begin
        state_q <= IDLE;
        ready_q <= 1'b0;
      end else if (prog_start) begin
        state_q <= LOAD;
        ready_q <= 1'b1;
        count_q <= '0;
        acc_q   <= '0;
      end else if (xfer) begin
        case (state_q)
          LOAD: begin
            acc_q   <= acc_q ^ prog_data;
            count_q <= count_q + CNT_W'(1);
            if (count_q == CNT_W'(NUM_WORDS - 1)) state_q <= CSUM;
          end
          CSUM: begin
            state_q <= IDLE;
            ready_q <= 1'b0;
            if (prog_data == acc_q) done_q <= 1'b1;
            else                    err_q  <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  pal_fuse_shadow #(
    .WORD_W   (WORD_W),
    .NUM_WORDS(NUM_WORDS),
    .FUSE_BITS(FUSE_BITS),
    .IDX_W    (CNT_W)
  ) u_shadow (
    .clk             (clk),
    .rst_n           (rst_n),
    .clr_i           (shadow_clr),
    .wr_en_i         (word_wr),
    .wr_idx_i        (count_q),
    .wr_data_i       (prog_data),
    .commit_i        (csum_ok_commit),
    .fuse_map_o      (fuse_map),
    .fuse_map_valid_o(fuse_map_valid)
  );

  assign prog_ready = ready_q;
  assign prog_done  = done_q;
  assign prog_err   = err_q;

endmodule

// File: tb/tb_pal_fuse_loader.sv
// Directed bench for pal_fuse_loader with a queue-based load model checked every cycle.
module tb_pal_fuse_loader;

  localparam int NW = 5;
  localparam int FB = 40;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          prog_start = 1'b0;
  logic          prog_abort = 1'b0;
  logic          prog_valid = 1'b0;
  logic [7:0]    prog_data = 8'h00;
  logic          prog_ready;
  logic          prog_done;
  logic          prog_err;
  logic [FB-1:0] fuse_map;
  logic          fuse_map_valid;

  int n_tests = 0;
  int n_fail  = 0;
  int done_cnt = 0;
  int err_cnt  = 0;

  pal_fuse_loader #(.NUM_INPUTS(5), .NUM_TERMS(4), .WORD_W(8)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .prog_start    (prog_start),
    .prog_abort    (prog_abort),
    .prog_valid    (prog_valid),
    .prog_data     (prog_data),
    .prog_ready    (prog_ready),
    .prog_done     (prog_done),
    .prog_err      (prog_err),
    .fuse_map      (fuse_map),
    .fuse_map_valid(fuse_map_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: a load is "open" after start; collected words form the map once the
  // checksum word (the word after NUM_WORDS data words) matches their XOR.
  logic          m_open = 1'b0;
  logic [7:0]    m_words[$];
  logic [FB-1:0] m_map = '0;
  logic          m_valid = 1'b0;
  logic          m_done = 1'b0;
  logic          m_err = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_open = 1'b0; m_words.delete(); m_map = '0;
      m_valid = 1'b0; m_done = 1'b0; m_err = 1'b0;
    end else begin
      m_done = 1'b0;
      m_err  = 1'b0;
      if (prog_abort) begin
        m_open = 1'b0;
        m_words.delete();
      end else if (prog_start) begin
        m_open = 1'b1;
        m_words.delete();
      end else if (m_open && prog_valid) begin
        m_words.push_back(prog_data);
        if (m_words.size() == NW + 1) begin
          logic [7:0]      x;
          logic [NW*8-1:0] full;
          x = 8'h00;
          for (int i = 0; i < NW; i++) begin
            x = x ^ m_words[i];
            full[i*8 +: 8] = m_words[i];
          end
          if (x == m_words[NW]) begin
            m_map = full[FB-1:0]; m_valid = 1'b1; m_done = 1'b1;
          end else begin
            m_err = 1'b1;
          end
          m_open = 1'b0;
          m_words.delete();
        end
      end
    end
  end

  always @(negedge clk) begin
    check("ready", prog_ready, m_open);
    check("done", prog_done, m_done);
    check("err", prog_err, m_err);
    check("map", fuse_map, m_map);
    check("map_valid", fuse_map_valid, m_valid);
    if (prog_done) done_cnt++;
    if (prog_err)  err_cnt++;
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic start_load();
    prog_start = 1'b1;
    tick(1);
    prog_start = 1'b0;
  endtask

  task automatic send(input logic [7:0] d);
    int b;
    prog_valid = 1'b1;
    prog_data  = d;
    b = 0;
    while (!prog_ready && b < 20) begin tick(1); b++; end
    if (!prog_ready) check("ready_timeout", prog_ready, 1);
    tick(1);
    prog_valid = 1'b0;
  endtask

  task automatic good_stream(input bit gaps);
    logic [7:0] w[6];
    w = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h1F};
    for (int i = 0; i < 6; i++) begin
      send(w[i]);
      if (gaps && (i % 2 == 0)) tick(2);
    end
  endtask

  initial begin
    int d0;
    // Reset state, and ready must stay low after a mid-cycle release.
    #2;
    check("rst_ready", prog_ready, 0);
    check("rst_map", fuse_map, 0);
    #20 rst_n = 1'b1;
    tick(2);
    check("post_rst_ready", prog_ready, 0);
    check("post_rst_valid", fuse_map_valid, 0);

    // Good load.
    start_load();
    good_stream(1'b0);
    check("t2_done", prog_done, 1);
    check("t2_err", prog_err, 0);
    check("t2_map", fuse_map, 40'h10_08_04_02_01);
    check("t2_valid", fuse_map_valid, 1);
    check("t2_ready", prog_ready, 0);
    tick(1);
    check("t2_done_1cyc", prog_done, 0);

    // Bad checksum: AA^AA^AA^AA^AA = AA, 00 sent.
    start_load();
    for (int i = 0; i < NW; i++) send(8'hAA);
    send(8'h00);
    check("t3_err", prog_err, 1);
    check("t3_done", prog_done, 0);
    check("t3_map", fuse_map, 40'h10_08_04_02_01);
    check("t3_valid", fuse_map_valid, 1);

    // Abort with simultaneous start and a presented word.
    start_load();
    send(8'h33); send(8'h44); send(8'h55);
    d0 = done_cnt + err_cnt;
    prog_abort = 1'b1; prog_start = 1'b1; prog_valid = 1'b1; prog_data = 8'h66;
    tick(1);
    prog_abort = 1'b0; prog_start = 1'b0; prog_valid = 1'b0;
    check("t4_ready", prog_ready, 0);
    tick(3);
    check("t4_no_pulse", done_cnt + err_cnt, d0);
    check("t4_map", fuse_map, 40'h10_08_04_02_01);
    start_load();
    good_stream(1'b0);
    check("t4_done", prog_done, 1);

    // Gaps plus restart after word 2; word presented with the restart is dropped.
    tick(1);
    d0 = done_cnt;
    start_load();
    send(8'h01); tick(1); send(8'h02); tick(1);
    prog_start = 1'b1; prog_valid = 1'b1; prog_data = 8'h04;
    tick(1);
    prog_start = 1'b0; prog_valid = 1'b0;
    good_stream(1'b1);
    tick(2);
    check("t5_single_done", done_cnt - d0, 1);
    check("t5_err_none", prog_err, 0);
    check("t5_map", fuse_map, 40'h10_08_04_02_01);

    // Reset mid-load wipes even a committed map.
    start_load();
    good_stream(1'b0);
    start_load();
    send(8'hC3); send(8'h3C);
    #3 rst_n = 1'b0;
    #1;
    check("t6_map", fuse_map, 0);
    check("t6_valid", fuse_map_valid, 0);
    check("t6_ready", prog_ready, 0);
    check("t6_done", prog_done, 0);
    check("t6_err", prog_err, 0);
    #12 rst_n = 1'b1;
    tick(3);
    check("t6_post_ready", prog_ready, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
